// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
// The FIFO_RD_STATS_EN build option is consumed by fifo_rd_streamer.
package fifo_rd_pkg;

    localparam int BUF_DEPTH          = 3;
    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] occ_t;

    // Circular increment over BUF_DEPTH entries (2 -> 0).
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_q.sv
// Three-entry circular skid queue with push/pop, occupancy and head-of-queue data.
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_skid_q
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    occ_t                  occ_q,  occ_d;

    // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;

        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: storage is cleared on reset too, so the head word reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains syn_FIFO through rd_en/rd_data/rd_valid and presents the words on a valid/ready stream.
// Build option FIFO_RD_STATS_EN adds the 32-bit word_count handshake counter port.
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  err_unexp
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           word_count
`endif
);

    logic       inflight_q,  inflight_d;
    logic       err_unexp_q, err_unexp_d;
    occ_t       occ;
    logic [2:0] credit_used;
    logic       push;
    logic       pop;

    fifo_rd_skid_q #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_q (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    // Credit counts queued plus in-flight words; m_ready never reaches fifo_rd_en.
    always_comb begin
        credit_used = {1'b0, occ} + {2'b00, inflight_q};
        fifo_rd_en  = !rst && !fifo_empty && (credit_used < 3'(BUF_DEPTH));
        m_valid     = (occ != occ_t'(0));
        pop         = m_valid && m_ready;
        push        = fifo_rd_valid && inflight_q;
        inflight_d  = fifo_rd_en;
        err_unexp_d = err_unexp_q || (fifo_rd_valid && !inflight_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    assign err_unexp = err_unexp_q;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q + (pop ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Self-checking bench for fifo_rd_streamer: a small behavioural FIFO feeds the DUT,
// a directed vector table covers single-word and short back-pressure, hand sequences cover the rest.
module tb_fifo_rd_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_valid;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       err_unexp;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] word_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_streamer #(
        .DATA_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_valid (fifo_rd_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .err_unexp     (err_unexp)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_count    (word_count)
`endif
    );

    // Behavioural FIFO: one-cycle read latency, emptied by rst.
    logic [7:0] fmem [64];
    int         wp = 0;
    int         rp = 0;
    logic       mv_q = 1'b0;
    logic [7:0] md_q = 8'h00;
    logic       fv = 1'b0;
    logic [7:0] fd = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            rp   <= wp;
            mv_q <= 1'b0;
        end else if (fifo_rd_en && (wp != rp)) begin
            md_q <= fmem[rp % 64];
            rp   <= rp + 1;
            mv_q <= 1'b1;
        end else begin
            mv_q <= 1'b0;
        end
    end

    assign fifo_empty    = (wp == rp);
    assign fifo_rd_valid = mv_q | fv;
    assign fifo_rd_data  = fv ? fd : md_q;

    task automatic fifo_write(input logic [7:0] d);
        fmem[wp % 64] = d;
        wp = wp + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Enters and leaves at a falling edge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       push;
        logic [7:0] wdata;
        logic       e_rd_en;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_err;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    int         got, first_c, last_c, pops, nexp;
    logic       hold;
    logic [7:0] hold_d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst   rdy   push  wdata  rd_en valid data   err
        vt[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0};

        @(negedge clk);
        @(negedge clk);

        // Directed vector table: single word, ready-while-empty, short back-pressure.
        for (int i = 0; i < NV; i++) begin
            rst     = vt[i].rst;
            m_ready = vt[i].rdy;
            if (vt[i].push) fifo_write(vt[i].wdata);
            #1;
            check($sformatf("vec%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, vt[i].e_rd_en});
            check($sformatf("vec%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vt[i].e_valid});
            check($sformatf("vec%0d_m_data", i), {24'd0, m_data}, {24'd0, vt[i].e_data});
            check($sformatf("vec%0d_err", i), {31'd0, err_unexp}, {31'd0, vt[i].e_err});
            @(negedge clk);
        end

        // Streaming 16 words at one word per cycle.
        do_reset();
        m_ready = 1'b1;
        for (int k = 1; k <= 16; k++) fifo_write(8'(k));
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c < 16) check("stream_rd_en", {31'd0, fifo_rd_en}, 32'd1);
            if (m_valid) begin
                check("stream_data", {24'd0, m_data}, 32'(got + 1));
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            @(negedge clk);
        end
        check("stream_count", 32'(got), 32'd16);
        check("stream_first_latency", 32'(first_c), 32'd2);
        check("stream_run_length", 32'(last_c - first_c), 32'd15);
`ifdef FIFO_RD_STATS_EN
        #1;
        check("stream_word_count", word_count, 32'd16);
        @(negedge clk);
`endif

        // Back-pressure: only three reads while m_ready is low.
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 8; k++) fifo_write(8'(k));
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fifo_rd_en) pops++;
            @(negedge clk);
        end
        #1;
        check("bp_reads_issued", 32'(pops), 32'd3);
        check("bp_m_valid", {31'd0, m_valid}, 32'd1);
        check("bp_head", {24'd0, m_data}, 32'h01);
        check("bp_rd_en_stalled", {31'd0, fifo_rd_en}, 32'd0);

        // Restart with m_ready toggling 1/0; order and stability while stalled.
        m_ready = 1'b1;
        nexp = 1;
        hold = 1'b0;
        hold_d = 8'h00;
        for (int c = 0; c < 60 && nexp <= 8; c++) begin
            if (c == 0) check("bp_restart_same_cycle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            if (c == 1) check("bp_restart_next_rd_en", {31'd0, fifo_rd_en}, 32'd1);
            if (hold) check("bp_stable", {24'd0, m_data}, {24'd0, hold_d});
            if (m_valid && m_ready) begin
                check("bp_order", {24'd0, m_data}, 32'(nexp));
                nexp++;
            end
            hold   = m_valid && !m_ready;
            hold_d = m_data;
            @(negedge clk);
            #1;
            m_ready = ~m_ready;
        end
        check("bp_all_delivered", 32'(nexp), 32'd9);
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("bp_no_duplicate", {31'd0, m_valid}, 32'd0);
        @(negedge clk);

        // Reset mid-burst with occ=2 and one read in flight.
        do_reset();
        m_ready = 1'b0;
        for (int k = 1; k <= 10; k++) fifo_write(8'(k));
        repeat (3) @(negedge clk);
        #1;
        check("mid_pre_valid", {31'd0, m_valid}, 32'd1);
        check("mid_pre_data", {24'd0, m_data}, 32'h01);
        rst = 1'b1;
        #1;
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_post_valid", {31'd0, m_valid}, 32'd0);
        check("mid_post_data", {24'd0, m_data}, 32'h00);
        check("mid_post_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("mid_post_err", {31'd0, err_unexp}, 32'd0);
`ifdef FIFO_RD_STATS_EN
        check("mid_post_word_count", word_count, 32'd0);
`endif
        @(negedge clk);
        fifo_write(8'h55);
        m_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (m_valid) begin
                check("mid_refill_data", {24'd0, m_data}, 32'h55);
                pops++;
            end
            @(negedge clk);
        end
        check("mid_refill_count", 32'(pops), 32'd1);

        // Unexpected rd_valid with no read outstanding.
        do_reset();
        m_ready = 1'b0;
        fifo_write(8'h3C);
        repeat (2) @(negedge clk);
        #1;
        check("err_pre_valid", {31'd0, m_valid}, 32'd1);
        check("err_pre_data", {24'd0, m_data}, 32'h3C);
        fv = 1'b1;
        fd = 8'h99;
        check("err_not_yet", {31'd0, err_unexp}, 32'd0);
        @(negedge clk);
        fv = 1'b0;
        #1;
        check("err_set", {31'd0, err_unexp}, 32'd1);
        check("err_queue_valid", {31'd0, m_valid}, 32'd1);
        check("err_queue_data", {24'd0, m_data}, 32'h3C);
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        check("err_dropped_word", {31'd0, m_valid}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", {31'd0, err_unexp}, 32'd1);
        @(negedge clk);
        do_reset();
        #1;
        check("err_cleared", {31'd0, err_unexp}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
